// File: rtl/serial_borrow_lookahead_subtractor_pkg.sv
// Shared definitions for the serial borrow-lookahead subtractor.
// Holds the digit width, the FSM state encoding and a small helper
// that evaluates two's-complement overflow from the operand and result
// sign bits.
package serial_borrow_lookahead_subtractor_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Subtraction overflows only when the operands differ in sign and the
    // result's sign no longer matches the minuend. The borrow-in cannot
    // change this outcome, so only the three sign bits are needed.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_borrow_lookahead_subtractor_cla4_sub.sv
// cla4_sub: combinational 4-bit borrow-lookahead subtract slice.
// Ports:
//   a4    in  4  minuend digit
//   b4    in  4  subtrahend digit
//   c_in  in  1  borrow into the digit
//   d4    out 4  a4 - b4 - c_in (low 4 bits)
//   c_out out 1  borrow out of the digit
module cla4_sub
    import serial_borrow_lookahead_subtractor_pkg::*;
(
    input  logic [DIGIT_W-1:0] a4,
    input  logic [DIGIT_W-1:0] b4,
    input  logic               c_in,
    output logic [DIGIT_W-1:0] d4,
    output logic               c_out
);

    logic [DIGIT_W-1:0] g;
    logic [DIGIT_W-1:0] p;
    logic [DIGIT_W:0]   c;

    // A bit generates a borrow when it is 0 and the subtrahend bit is 1;
    // it passes an incoming borrow through when the two bits are equal.
    // Every borrow is expanded directly from c_in so no bit waits on the
    // previous one.
    always_comb begin
        g    = ~a4 & b4;
        p    = ~(a4 ^ b4);
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_in);
        d4    = a4 ^ b4 ^ c[DIGIT_W-1:0];
        c_out = c[DIGIT_W];
    end

endmodule

// File: rtl/serial_borrow_lookahead_subtractor.sv
// serial_borrow_lookahead_subtractor: computes a - b - bin over WIDTH bits,
// one 4-bit digit per clock (LSB digit first). A single cla4_sub slice is
// reused for every digit, and the borrow between digits is kept in a register.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, bin)
//   out_valid/out_ready result handshake (diff, bout, zero, ovf)
//   diff  a - b - bin modulo 2^WIDTH
//   bout  unsigned borrow-out
//   zero  diff == 0
//   ovf   two's-complement overflow
module serial_borrow_lookahead_subtractor
    import serial_borrow_lookahead_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int DIGITS = WIDTH / DIGIT_W;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   diff_reg;
    logic [WIDTH-1:0]   diff_next;
    logic               borrow_reg;
    logic               bout_reg;
    logic               zero_reg;
    logic               ovf_reg;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [DIGIT_W-1:0] d_dig;
    logic               c4;
    logic               accept;
    logic               last_digit;

    assign accept     = in_valid & in_ready;
    assign last_digit = (state == RUN) && (cnt == LAST);

    // State register. Reset forces IDLE, which also abandons any operation
    // that is in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake logic. in_ready is gated by rst_n so that it
    // stays low for as long as reset is held. The default branch sends the
    // unused encoding back to IDLE.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Select the current digit from the captured operands. The input ports
    // are never read here, so they cannot disturb a running operation.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (cnt == CNT_W'(k)) begin
                a_dig = a_reg[k*DIGIT_W +: DIGIT_W];
                b_dig = b_reg[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

    cla4_sub u_slice (
        .a4    (a_dig),
        .b4    (b_dig),
        .c_in  (borrow_reg),
        .d4    (d_dig),
        .c_out (c4)
    );

    // Merge the new digit into the result. On the last digit the flags are
    // computed from this merged value, so they see the complete result.
    always_comb begin
        diff_next = diff_reg;
        for (int k = 0; k < DIGITS; k++) begin
            if (cnt == CNT_W'(k)) begin
                diff_next[k*DIGIT_W +: DIGIT_W] = d_dig;
            end
        end
    end

    // Datapath registers: operand capture on accept, one digit per RUN cycle,
    // and flags on the final digit. The results are held until the next
    // operation overwrites them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            bout_reg   <= 1'b0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            cnt        <= '0;
        end else if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= bin;
            cnt        <= '0;
        end else if (state == RUN) begin
            diff_reg   <= diff_next;
            borrow_reg <= c4;
            cnt        <= cnt + 1'b1;
            if (last_digit) begin
                bout_reg <= c4;
                zero_reg <= (diff_next == '0);
                ovf_reg  <= signed_ovf(a_reg[WIDTH-1], b_reg[WIDTH-1],
                                       diff_next[WIDTH-1]);
            end
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;
    assign zero = zero_reg;
    assign ovf  = ovf_reg;

endmodule
